// File: rtl/up_axi_lite_initiator_pkg.sv
// Shared types and constants for the AXI4-Lite to up-bus initiator bridge.
`timescale 1ns/1ps
package up_axi_lite_initiator_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        XFER_IDLE = 2'd0,
        XFER_REQ  = 2'd1,
        XFER_WAIT = 2'd2,
        XFER_RESP = 2'd3
    } xfer_state_t;

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/up_xfer_fsm.sv
// One up-bus transfer: request strobe, ack wait with timeout, held AXI response.
`timescale 1ns/1ps
module up_xfer_fsm
    import up_axi_lite_initiator_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hdead_dead
) (
    input  logic        up_clk,
    input  logic        up_rstn,
    input  logic        start,
    input  logic        ack,
    input  logic [31:0] ack_data,
    input  logic        resp_ready,
    output logic        req,
    output logic        resp_valid,
    output logic [1:0]  resp,
    output logic [31:0] resp_data,
    output xfer_state_t state
);

    localparam int            CW       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state      <= XFER_IDLE;
            req        <= 1'b0;
            resp_valid <= 1'b0;
            resp       <= RESP_OKAY;
            resp_data  <= 32'h0;
            cnt        <= '0;
        end else begin
            case (state)
                XFER_IDLE: begin
                    if (start) begin
                        state <= XFER_REQ;
                        req   <= 1'b1;
                    end
                end
                XFER_REQ: begin
                    req   <= 1'b0;
                    cnt   <= '0;
                    state <= XFER_WAIT;
                end
                XFER_WAIT: begin
                    // An ack in the final wait cycle still beats the timeout.
                    if (ack) begin
                        state      <= XFER_RESP;
                        resp_valid <= 1'b1;
                        resp       <= RESP_OKAY;
                        resp_data  <= ack_data;
                    end else if (cnt == CNT_LAST) begin
                        state      <= XFER_RESP;
                        resp_valid <= 1'b1;
                        resp       <= RESP_SLVERR;
                        resp_data  <= TIMEOUT_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER_RESP: begin
                    if (resp_ready) begin
                        state      <= XFER_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= XFER_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/up_axi_lite_initiator.sv
// AXI4-Lite slave to up-bus initiator: independent write and read transfer paths.
`timescale 1ns/1ps
module up_axi_lite_initiator
    import up_axi_lite_initiator_pkg::*;
#(
    parameter int          ADDRESS_WIDTH     = 14,
    parameter int          AXI_ADDRESS_WIDTH = 16,
    parameter int          TIMEOUT_CYCLES    = 64,
    parameter logic [31:0] TIMEOUT_DATA      = 32'hdead_dead
) (
    input  logic                         up_clk,
    input  logic                         up_rstn,
    input  logic                         s_axi_awvalid,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_awaddr,
    output logic                         s_axi_awready,
    input  logic                         s_axi_wvalid,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    output logic                         s_axi_wready,
    output logic                         s_axi_bvalid,
    output logic [1:0]                   s_axi_bresp,
    input  logic                         s_axi_bready,
    input  logic                         s_axi_arvalid,
    input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_araddr,
    output logic                         s_axi_arready,
    output logic                         s_axi_rvalid,
    output logic [31:0]                  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    input  logic                         s_axi_rready,
    output logic                         up_wreq,
    output logic [ADDRESS_WIDTH-1:0]     up_waddr,
    output logic [31:0]                  up_wdata,
    input  logic                         up_wack,
    output logic                         up_rreq,
    output logic [ADDRESS_WIDTH-1:0]     up_raddr,
    input  logic [31:0]                  up_rdata,
    input  logic                         up_rack
);

    // Handshake rule: a channel completes on a rising edge where valid && ready;
    // ready is offered only in IDLE and, for writes, only when AW and W are both valid.
    logic        accept_en;
    logic        wr_accept;
    logic        rd_accept;
    xfer_state_t wr_state;
    xfer_state_t rd_state;
    logic [31:0] wr_resp_data;
    logic        unused_inputs;

    // Keeps every ready low while reset is asserted, whatever the valids do.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            accept_en <= 1'b0;
        end else begin
            accept_en <= 1'b1;
        end
    end

    assign wr_accept     = accept_en && (wr_state == XFER_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign rd_accept     = accept_en && (rd_state == XFER_IDLE) && s_axi_arvalid;
    assign s_axi_awready = wr_accept;
    assign s_axi_wready  = wr_accept;
    assign s_axi_arready = rd_accept;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            up_waddr <= '0;
            up_wdata <= 32'h0;
            up_raddr <= '0;
        end else begin
            if (wr_accept) begin
                up_waddr <= s_axi_awaddr[AXI_ADDRESS_WIDTH-1:2];
                up_wdata <= s_axi_wdata;
            end
            if (rd_accept) begin
                up_raddr <= s_axi_araddr[AXI_ADDRESS_WIDTH-1:2];
            end
        end
    end

    up_xfer_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_DATA   (TIMEOUT_DATA)
    ) i_wr_fsm (
        .up_clk     (up_clk),
        .up_rstn    (up_rstn),
        .start      (wr_accept),
        .ack        (up_wack),
        .ack_data   (32'h0),
        .resp_ready (s_axi_bready),
        .req        (up_wreq),
        .resp_valid (s_axi_bvalid),
        .resp       (s_axi_bresp),
        .resp_data  (wr_resp_data),
        .state      (wr_state)
    );

    up_xfer_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_DATA   (TIMEOUT_DATA)
    ) i_rd_fsm (
        .up_clk     (up_clk),
        .up_rstn    (up_rstn),
        .start      (rd_accept),
        .ack        (up_rack),
        .ack_data   (up_rdata),
        .resp_ready (s_axi_rready),
        .req        (up_rreq),
        .resp_valid (s_axi_rvalid),
        .resp       (s_axi_rresp),
        .resp_data  (s_axi_rdata),
        .state      (rd_state)
    );

    // Byte lanes and byte offsets carry no information on a word-only bus.
    assign unused_inputs = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0], wr_resp_data};

endmodule

// File: tb/tb_up_axi_lite_initiator.sv
// Directed bench for up_axi_lite_initiator with a transaction-timeline reference model.
`timescale 1ns/1ps
module tb_up_axi_lite_initiator;

    localparam int          T_CYC = 64;
    localparam logic [31:0] T_DAT = 32'hdead_dead;

    logic        up_clk = 1'b0;
    logic        up_rstn = 1'b0;
    logic        s_axi_awvalid = 1'b0;
    logic [15:0] s_axi_awaddr = 16'h0;
    logic        s_axi_awready;
    logic        s_axi_wvalid = 1'b0;
    logic [31:0] s_axi_wdata = 32'h0;
    logic [3:0]  s_axi_wstrb = 4'hf;
    logic        s_axi_wready;
    logic        s_axi_bvalid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0;
    logic [15:0] s_axi_araddr = 16'h0;
    logic        s_axi_arready;
    logic        s_axi_rvalid;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rready = 1'b0;
    logic        up_wreq;
    logic [13:0] up_waddr;
    logic [31:0] up_wdata;
    logic        up_wack = 1'b0;
    logic        up_rreq;
    logic [13:0] up_raddr;
    logic [31:0] up_rdata = 32'h0;
    logic        up_rack = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    up_axi_lite_initiator #(
        .ADDRESS_WIDTH     (14),
        .AXI_ADDRESS_WIDTH (16),
        .TIMEOUT_CYCLES    (T_CYC),
        .TIMEOUT_DATA      (T_DAT)
    ) dut (
        .up_clk        (up_clk),
        .up_rstn       (up_rstn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awready (s_axi_awready),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arready (s_axi_arready),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rready  (s_axi_rready),
        .up_wreq       (up_wreq),
        .up_waddr      (up_waddr),
        .up_wdata      (up_wdata),
        .up_wack       (up_wack),
        .up_rreq       (up_rreq),
        .up_raddr      (up_raddr),
        .up_rdata      (up_rdata),
        .up_rack       (up_rack)
    );

    // ---------------- clock ----------------
    always #5 up_clk = ~up_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge up_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timed_out(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no DUT response within the cycle budget (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // Each direction is a timeline: accepted at cycle acc, request at acc+1,
    // ack window acc+2 .. acc+1+T_CYC, response from fin onwards until ready.
    int          cyc = 0;
    bit          w_busy = 0, r_busy = 0;
    int          w_acc, w_fin, r_acc, r_fin;
    logic [1:0]  w_resp_m, r_resp_m;
    logic [31:0] r_data_m;
    logic [13:0] w_addr_m = 0, r_addr_m = 0;
    logic [31:0] w_data_m = 0;

    always @(negedge up_clk) begin
        bit w_rdy, w_bv, r_rdy, r_bv;
        cyc++;
        if (!up_rstn) begin
            w_busy = 0; r_busy = 0;
            w_addr_m = 0; w_data_m = 0; r_addr_m = 0;
            check("rst_awready", s_axi_awready, 0);
            check("rst_wready", s_axi_wready, 0);
            check("rst_arready", s_axi_arready, 0);
            check("rst_bvalid", s_axi_bvalid, 0);
            check("rst_rvalid", s_axi_rvalid, 0);
            check("rst_wreq", up_wreq, 0);
            check("rst_rreq", up_rreq, 0);
            check("rst_waddr", up_waddr, 0);
            check("rst_wdata", up_wdata, 0);
            check("rst_raddr", up_raddr, 0);
        end else begin
            w_rdy = !w_busy && s_axi_awvalid && s_axi_wvalid;
            w_bv  = w_busy && (w_fin >= 0) && (cyc >= w_fin);
            r_rdy = !r_busy && s_axi_arvalid;
            r_bv  = r_busy && (r_fin >= 0) && (cyc >= r_fin);

            check("awready", s_axi_awready, w_rdy);
            check("wready", s_axi_wready, w_rdy);
            check("wreq", up_wreq, w_busy && cyc == w_acc + 1);
            check("bvalid", s_axi_bvalid, w_bv);
            check("waddr", up_waddr, w_addr_m);
            check("wdata", up_wdata, w_data_m);
            if (w_bv) check("bresp", s_axi_bresp, w_resp_m);
            check("arready", s_axi_arready, r_rdy);
            check("rreq", up_rreq, r_busy && cyc == r_acc + 1);
            check("rvalid", s_axi_rvalid, r_bv);
            check("raddr", up_raddr, r_addr_m);
            if (r_bv) begin
                check("rresp", s_axi_rresp, r_resp_m);
                check("rdata", s_axi_rdata, r_data_m);
            end

            if (w_rdy) begin
                w_busy = 1; w_acc = cyc; w_fin = -1;
                w_addr_m = s_axi_awaddr[15:2]; w_data_m = s_axi_wdata;
            end else if (w_busy && w_fin < 0 && cyc >= w_acc + 2) begin
                if (up_wack) begin
                    w_fin = cyc + 1; w_resp_m = 2'b00;
                end else if (cyc == w_acc + 1 + T_CYC) begin
                    w_fin = cyc + 1; w_resp_m = 2'b10;
                end
            end
            if (w_bv && s_axi_bready) w_busy = 0;

            if (r_rdy) begin
                r_busy = 1; r_acc = cyc; r_fin = -1;
                r_addr_m = s_axi_araddr[15:2];
            end else if (r_busy && r_fin < 0 && cyc >= r_acc + 2) begin
                if (up_rack) begin
                    r_fin = cyc + 1; r_resp_m = 2'b00; r_data_m = up_rdata;
                end else if (cyc == r_acc + 1 + T_CYC) begin
                    r_fin = cyc + 1; r_resp_m = 2'b10; r_data_m = T_DAT;
                end
            end
            if (r_bv && s_axi_rready) r_busy = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                             input int w_lag, output time t_hs);
        bit seen = 0;
        t_hs = 0;
        s_axi_awaddr = addr;
        s_axi_wdata = data;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < w_lag; i++) begin
            @(negedge up_clk);
            check("aw_alone_awready", s_axi_awready, 0);
            check("aw_alone_wready", s_axi_wready, 0);
            tick(1);
        end
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge up_clk);
            if (s_axi_awready) begin
                seen = 1;
                t_hs = $time;
            end
        end
        if (!seen) timed_out("aw_handshake");
        tick(1);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] addr, output time t_hs);
        bit seen = 0;
        t_hs = 0;
        s_axi_araddr = addr;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge up_clk);
            if (s_axi_arready) begin
                seen = 1;
                t_hs = $time;
            end
        end
        if (!seen) timed_out("ar_handshake");
        tick(1);
        s_axi_arvalid = 1'b0;
    endtask

    // Waits for the request strobe, then acks d cycles later (d=1: first wait cycle).
    task automatic ack_write(input int d);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge up_clk);
            if (up_wreq) seen = 1;
        end
        if (!seen) begin
            timed_out("wreq_wait");
        end else begin
            tick(d);
            up_wack = 1'b1;
            tick(1);
            up_wack = 1'b0;
        end
    endtask

    task automatic ack_read(input int d, input logic [31:0] data);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge up_clk);
            if (up_rreq) seen = 1;
        end
        if (!seen) begin
            timed_out("rreq_wait");
        end else begin
            tick(d);
            up_rack = 1'b1;
            up_rdata = data;
            tick(1);
            up_rack = 1'b0;
            up_rdata = 32'h0;
        end
    endtask

    task automatic wait_b(input int ready_lag, output time t_v, output logic [1:0] resp);
        bit seen = 0;
        t_v = 0;
        resp = 2'bxx;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge up_clk);
            if (s_axi_bvalid) begin
                seen = 1;
                t_v = $time;
                resp = s_axi_bresp;
            end
        end
        if (!seen) begin
            timed_out("bvalid_wait");
        end else begin
            tick(1 + ready_lag);
            s_axi_bready = 1'b1;
            tick(1);
            s_axi_bready = 1'b0;
        end
    endtask

    // stray_at >= 0 pulses a spurious rack that many cycles into the hold-off.
    task automatic wait_r(input int ready_lag, input int stray_at, output time t_v,
                          output logic [1:0] resp, output logic [31:0] data);
        bit seen = 0;
        t_v = 0;
        resp = 2'bxx;
        data = 32'hx;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge up_clk);
            if (s_axi_rvalid) begin
                seen = 1;
                t_v = $time;
                resp = s_axi_rresp;
                data = s_axi_rdata;
            end
        end
        if (!seen) begin
            timed_out("rvalid_wait");
        end else begin
            tick(1);
            for (int i = 0; i < ready_lag; i++) begin
                up_rack = (i == stray_at);
                up_rdata = (i == stray_at) ? 32'h0bad_0bad : 32'h0;
                tick(1);
            end
            up_rack = 1'b0;
            up_rdata = 32'h0;
            s_axi_rready = 1'b1;
            tick(1);
            s_axi_rready = 1'b0;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        time        t_hs, t_hs2, t_v;
        logic [1:0] resp;
        logic [31:0] data;

        tick(3);
        up_rstn = 1'b1;
        tick(3);

        // Spurious ack while idle must not start or complete anything.
        up_wack = 1'b1;
        up_rack = 1'b1;
        tick(1);
        up_wack = 1'b0;
        up_rack = 1'b0;
        tick(2);

        // Basic write, ack two cycles after the strobe.
        axi_write(16'h0040, 32'h1234_5678, 0, t_hs);
        ack_write(2);
        check("t1_waddr", up_waddr, 14'h0010);
        check("t1_wdata", up_wdata, 32'h1234_5678);
        wait_b(1, t_v, resp);
        check("t1_bresp", resp, 2'b00);
        check("t1_latency", int'((t_v - t_hs) / 10), 4);
        tick(2);

        // AW leads W by five cycles; ack in the first wait cycle gives minimum latency.
        axi_write(16'h0100, 32'ha5a5_0002, 5, t_hs);
        ack_write(1);
        wait_b(0, t_v, resp);
        check("t2_waddr", up_waddr, 14'h0040);
        check("t2_bresp", resp, 2'b00);
        check("t2_latency", int'((t_v - t_hs) / 10), 3);
        tick(2);

        // Read with rready held off for four cycles.
        axi_read(16'h0008, t_hs);
        ack_read(1, 32'hcafe_0001);
        wait_r(4, -1, t_v, resp, data);
        check("t3_raddr", up_raddr, 14'h0002);
        check("t3_rdata", data, 32'hcafe_0001);
        check("t3_rresp", resp, 2'b00);
        tick(2);

        // Read timeout, then a late ack, then a normal read.
        axi_read(16'h0010, t_hs);
        wait_r(6, 2, t_v, resp, data);
        check("t4_latency", int'((t_v - t_hs) / 10), 66);
        check("t4_rdata", data, 32'hdead_dead);
        check("t4_rresp", resp, 2'b10);
        tick(2);
        axi_read(16'h0014, t_hs);
        ack_read(3, 32'h5a5a_0003);
        wait_r(0, -1, t_v, resp, data);
        check("t4b_rdata", data, 32'h5a5a_0003);
        check("t4b_rresp", resp, 2'b00);
        tick(2);

        // Ack in the last wait cycle wins; one cycle later is a timeout.
        axi_write(16'h0200, 32'h0000_0005, 0, t_hs);
        ack_write(64);
        wait_b(0, t_v, resp);
        check("t5_bresp_edge", resp, 2'b00);
        check("t5_latency", int'((t_v - t_hs) / 10), 66);
        tick(2);
        axi_write(16'h0204, 32'h0000_0006, 0, t_hs);
        ack_write(65);
        wait_b(0, t_v, resp);
        check("t5b_bresp_late", resp, 2'b10);
        tick(2);

        // Simultaneous write and read, read acked first.
        s_axi_awaddr = 16'h0300;
        s_axi_wdata = 32'h600d_0006;
        s_axi_araddr = 16'h0304;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        s_axi_arvalid = 1'b1;
        @(negedge up_clk);
        check("t6_awready", s_axi_awready, 1);
        check("t6_arready", s_axi_arready, 1);
        tick(1);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        fork
            begin
                @(negedge up_clk);
                check("t6_wreq", up_wreq, 1);
                check("t6_rreq", up_rreq, 1);
            end
            ack_read(1, 32'h7777_0007);
            ack_write(3);
        join
        fork
            begin
                logic [1:0] br;
                time        tb;
                wait_b(0, tb, br);
                check("t6_bresp", br, 2'b00);
            end
            begin
                wait_r(2, -1, t_v, resp, data);
                check("t6_rdata", data, 32'h7777_0007);
                check("t6_rresp", resp, 2'b00);
            end
        join
        tick(2);

        // Reset while waiting for an ack abandons the write.
        axi_write(16'h0044, 32'h0000_abcd, 0, t_hs2);
        @(negedge up_clk);
        check("t7_wreq", up_wreq, 1);
        tick(3);
        up_rstn = 1'b0;
        #1;
        check("t7_rst_wreq", up_wreq, 0);
        check("t7_rst_waddr", up_waddr, 0);
        check("t7_rst_bvalid", s_axi_bvalid, 0);
        tick(3);
        up_rstn = 1'b1;
        tick(10);
        check("t7_no_bvalid", s_axi_bvalid, 0);
        axi_write(16'h0048, 32'h0000_beef, 0, t_hs);
        ack_write(2);
        wait_b(0, t_v, resp);
        check("t7_bresp", resp, 2'b00);
        check("t7_waddr", up_waddr, 14'h0012);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

endmodule

// File: doc/up_axi_lite_initiator.md
Name:
up_axi_lite_initiator

Overview:
- AXI4-Lite slave to up-bus initiator bridge.
- Converts AXI4-Lite accesses into the single-cycle up_wreq/up_rreq strobes that every up_* responder decodes, e.g. the up_dac_common and channel register banks of the DAC/ADC JESD204 cores.
- Sits between the interconnect and a core's up port.
- Independent write and read paths; each path has a timeout so a missing responder never hangs the bus.

Parameters:
- ADDRESS_WIDTH, 14, width of up_waddr/up_raddr (word address).
- AXI_ADDRESS_WIDTH, 16, width of s_axi_awaddr/araddr (byte address); must equal ADDRESS_WIDTH+2.
- TIMEOUT_CYCLES, 64, cycles to wait for ack after a request before forcing a response; range 2..1023.
- TIMEOUT_DATA, 32'hdead_dead, read data returned on timeout.

Ports:
- up_clk  in  1  single clock for AXI and up sides.
- up_rstn  in  1  reset, asynchronous assert, active-low.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awaddr  in  AXI_ADDRESS_WIDTH  write byte address.
- s_axi_awready  out  1  write address ready.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  ignored; all writes are full-word.
- s_axi_wready  out  1  write data ready.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR (timeout).
- s_axi_bready  in  1  write response ready.
- s_axi_arvalid  in  1  read address valid.
- s_axi_araddr  in  AXI_ADDRESS_WIDTH  read byte address.
- s_axi_arready  out  1  read address ready.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  as bresp.
- s_axi_rready  in  1  read data ready.
- up_wreq  out  1  one-cycle write strobe.
- up_waddr  out  ADDRESS_WIDTH  write word address.
- up_wdata  out  32  write data.
- up_wack  in  1  write acknowledge.
- up_rreq  out  1  one-cycle read strobe.
- up_raddr  out  ADDRESS_WIDTH  read word address.
- up_rdata  in  32  read data, valid when up_rack=1.
- up_rack  in  1  read acknowledge.

Behaviour:
- Reset:
  - All outputs 0; both FSMs enter IDLE; timeout counters cleared.
  - Reset asserted mid-transaction abandons it; no response is issued after release.
- Write FSM, states IDLE, REQ, WAIT, RESP:
  - IDLE: awready=wready=1 only in a cycle where awvalid&&wvalid. AW and W are accepted together in that cycle N. Latch awaddr[AXI_ADDRESS_WIDTH-1:2] into up_waddr and wdata into up_wdata. Go to REQ.
  - IDLE, either channel valid alone: ready stays 0. The channel waits without being dropped.
  - REQ (cycle N+1): up_wreq=1 for exactly one cycle; counter=0; go to WAIT.
  - WAIT: up_wack is sampled only in this state. On wack=1, bresp=OKAY and go to RESP. Otherwise counter++; when counter reaches TIMEOUT_CYCLES-1 with no ack, bresp=SLVERR and go to RESP.
  - RESP: bvalid=1, held stable until bready. On bvalid&&bready, go to IDLE next cycle.
  - Minimum latency from AW/W handshake to bvalid is 3 cycles (ack arriving the first WAIT cycle).
  - up_waddr/up_wdata hold their values from REQ until the next accepted write.
- Read FSM, identical structure:
  - arready in IDLE when arvalid.
  - up_rreq pulses for one cycle in REQ.
  - On rack in WAIT, register up_rdata into rdata with rresp=OKAY.
  - On timeout, rdata=TIMEOUT_DATA and rresp=SLVERR.
  - rvalid held until rready.
- Read and write paths are fully independent. up_wreq and up_rreq may assert in the same cycle.
- Stray acks: an ack arriving in IDLE, REQ or RESP (late after timeout, spurious) is ignored and never completes a later transaction.
- Ack in the same cycle as the timeout: ack wins (OKAY).
- One outstanding transaction per direction; AXI IDs are not used.

Decomposition:
- Shared package holds:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - FSM state encodings (2-bit IDLE/REQ/WAIT/RESP);
  - the clog2-based counter width function.
- One sub-module is natural: up_xfer_fsm, the req/wait/timeout/response FSM with a counter. It is instantiated twice, once for write and once for read; the read instance also captures the data.

Test Plan:
- AW and W together, awaddr=16'h0040, wdata=32'h12345678, wack 2 cycles after wreq -> one wreq pulse, up_waddr=14'h0010, up_wdata=32'h12345678, bvalid with bresp=0.
- AW valid 5 cycles before W -> awready/wready both 0 until W valid, then both 1 in the same cycle; exactly one wreq.
- Read araddr=16'h0008, rack with up_rdata=32'hcafe0001 after 1 cycle, rready held low 4 cycles -> up_raddr=14'h0002, rvalid stays 1 and rdata stable until rready, rresp=0.
- Read with no rack, TIMEOUT_CYCLES=64 -> rvalid after 64 WAIT cycles, rdata=32'hdead_dead, rresp=2'b10. A late rack 3 cycles later is ignored; the next read completes normally with its own data.
- Simultaneous read and write accepted in the same cycle -> wreq and rreq pulse in the same cycle; out-of-order acks (rack first) give correct independent responses.
- up_rstn low while in WAIT -> all outputs 0 immediately; after release no bvalid appears, and a fresh write completes OKAY.
